// File: rtl/alpha_path_exchanger.sv
// alpha_path_exchanger: merges the low-gain (HDR) and high-gain (LDR) ADC paths
// into one LDR-scaled stream. The alpha select flag is debounced, and the
// output then crossfades linearly over 2^XFADE_LOG2 samples.
// Optional build macro ZC_ALIGN_EN: the crossfade start is deferred to a zero
// crossing of the target path, with a forced start after 255 deferred samples.
module alpha_path_exchanger #(
   parameter int GAIN_SHIFT   = 4,
   parameter int XFADE_LOG2   = 3,
   parameter int HOLD_SAMPLES = 4
) (
   input  logic                    CLK_3M,
   input  logic                    reset,
   input  logic                    sample_valid,
   input  logic [8:0]              hdr_value,
   input  logic [8:0]              ldr_value,
   input  logic                    alpha,
   output logic [9+GAIN_SHIFT-1:0] out_sample,
   output logic                    out_valid,
   output logic                    path_sel,
   output logic                    xfade_busy
);

   localparam int OW = 9 + GAIN_SHIFT;
   localparam int IW = OW + XFADE_LOG2 + 1;
   localparam int N  = 1 << XFADE_LOG2;
   localparam int KW = XFADE_LOG2 + 1;
   localparam int HW = $clog2(HOLD_SAMPLES + 1);

   localparam logic [KW-1:0] K_ZERO = '0;
   localparam logic [KW-1:0] K_ONE  = KW'(1);
   localparam logic [KW-1:0] K_NM1  = KW'(N - 1);
   localparam logic [KW-1:0] K_FULL = KW'(N);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SAMPLES - 1);

   localparam logic [2:0] SEL_HDR      = 3'd0;
   localparam logic [2:0] XFADE_TO_LDR = 3'd1;
   localparam logic [2:0] SEL_LDR      = 3'd2;
   localparam logic [2:0] XFADE_TO_HDR = 3'd3;
`ifdef ZC_ALIGN_EN
   localparam logic [2:0] ZC_WAIT_LDR  = 3'd4;
   localparam logic [2:0] ZC_WAIT_HDR  = 3'd5;
   localparam logic [2:0] START_LDR    = ZC_WAIT_LDR;
   localparam logic [2:0] START_HDR    = ZC_WAIT_HDR;
`else
   localparam logic [2:0] START_LDR    = XFADE_TO_LDR;
   localparam logic [2:0] START_HDR    = XFADE_TO_HDR;
`endif

   logic [2:0]    state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          path_sel_q, path_sel_d;
   logic          busy_q, busy_d;
   logic          out_valid_q;
   logic [OW-1:0] out_q, out_d;
`ifdef ZC_ALIGN_EN
   logic [7:0]    wait_q, wait_d;
   logic          hdr_sgn_q, ldr_sgn_q;
`endif

   logic signed [IW-1:0] hdr_ext, ldr_ext, w_hdr, w_ldr, acc, scaled;

   // Debounce / crossfade state machine; everything advances only on valid samples
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      hold_d     = hold_q;
      path_sel_d = path_sel_q;
`ifdef ZC_ALIGN_EN
      wait_d     = wait_q;
`endif
      if (sample_valid) begin
         case (state_q)
            SEL_HDR: begin
               if (!alpha) begin
                  if (hold_q == HOLD_LAST) begin
                     hold_d  = '0;
                     state_d = START_LDR;
                  end else begin
                     hold_d = hold_q + HW'(1);
                  end
               end else begin
                  hold_d = '0;
               end
            end
            SEL_LDR: begin
               if (alpha) begin
                  if (hold_q == HOLD_LAST) begin
                     hold_d  = '0;
                     state_d = START_HDR;
                  end else begin
                     hold_d = hold_q + HW'(1);
                  end
               end else begin
                  hold_d = '0;
               end
            end
            XFADE_TO_LDR, XFADE_TO_HDR: begin
               // Direction follows the current alpha, so a reversal is immediate
               if (!alpha) begin
                  if (k_q >= K_NM1) begin
                     k_d        = K_FULL;
                     state_d    = SEL_LDR;
                     path_sel_d = 1'b1;
                  end else begin
                     k_d     = k_q + K_ONE;
                     state_d = XFADE_TO_LDR;
                  end
               end else begin
                  if (k_q <= K_ONE) begin
                     k_d        = K_ZERO;
                     state_d    = SEL_HDR;
                     path_sel_d = 1'b0;
                  end else begin
                     k_d     = k_q - K_ONE;
                     state_d = XFADE_TO_HDR;
                  end
               end
               hold_d = '0;
            end
`ifdef ZC_ALIGN_EN
            ZC_WAIT_LDR: begin
               if (alpha) begin
                  state_d = SEL_HDR;
                  hold_d  = '0;
                  wait_d  = '0;
               end else if ((ldr_value[8] != ldr_sgn_q) || (wait_q == 8'hFF)) begin
                  state_d = XFADE_TO_LDR;
                  k_d     = K_ONE;
                  wait_d  = '0;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end
            ZC_WAIT_HDR: begin
               if (!alpha) begin
                  state_d = SEL_LDR;
                  hold_d  = '0;
                  wait_d  = '0;
               end else if ((hdr_value[8] != hdr_sgn_q) || (wait_q == 8'hFF)) begin
                  state_d = XFADE_TO_HDR;
                  k_d     = K_NM1;
                  wait_d  = '0;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end
`endif
            default: begin
               state_d    = SEL_HDR;
               k_d        = K_ZERO;
               hold_d     = '0;
               path_sel_d = 1'b0;
            end
         endcase
      end
   end

   // Busy flag reflects the state the sample leaves us in
   always_comb begin
      busy_d = (state_d == XFADE_TO_LDR) || (state_d == XFADE_TO_HDR);
`ifdef ZC_ALIGN_EN
      busy_d = busy_d || (state_d == ZC_WAIT_LDR) || (state_d == ZC_WAIT_HDR);
`endif
   end

   // Weighted mix with the post-update weight; floor via arithmetic shift
   always_comb begin
      hdr_ext = {{(IW-9){hdr_value[8]}}, hdr_value} <<< GAIN_SHIFT;
      ldr_ext = {{(IW-9){ldr_value[8]}}, ldr_value};
      w_ldr   = {{(IW-KW){1'b0}}, k_d};
      w_hdr   = IW'(N) - w_ldr;
      acc     = hdr_ext * w_hdr + ldr_ext * w_ldr;
      scaled  = acc >>> XFADE_LOG2;
      out_d   = scaled[OW-1:0];
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge CLK_3M) begin
      if (!reset) begin
         state_q     <= SEL_HDR;
         k_q         <= K_ZERO;
         hold_q      <= '0;
         path_sel_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
`ifdef ZC_ALIGN_EN
         wait_q      <= '0;
         hdr_sgn_q   <= 1'b0;
         ldr_sgn_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         hold_q      <= hold_d;
         path_sel_q  <= path_sel_d;
         busy_q      <= busy_d;
         out_valid_q <= sample_valid;
         if (sample_valid) begin
            out_q <= out_d;
         end
`ifdef ZC_ALIGN_EN
         wait_q <= wait_d;
         if (sample_valid) begin
            hdr_sgn_q <= hdr_value[8];
            ldr_sgn_q <= ldr_value[8];
         end
`endif
      end
   end

   assign out_sample = out_q;
   assign out_valid  = out_valid_q;
   assign path_sel   = path_sel_q;
   assign xfade_busy = busy_q;

endmodule

// File: tb/tb_alpha_path_exchanger.sv
// Scoreboard bench for alpha_path_exchanger: directed scenarios followed by
// randomized samples, gaps and resets, checked against a weight-walking model.
module tb_alpha_path_exchanger;

   localparam int GS   = 4;
   localparam int XL   = 3;
   localparam int HOLD = 4;
   localparam int N    = 1 << XL;
   localparam int OW   = 9 + GS;

   logic          CLK_3M = 1'b0;
   logic          reset = 1'b0;
   logic          sample_valid = 1'b0;
   logic [8:0]    hdr_value = '0;
   logic [8:0]    ldr_value = '0;
   logic          alpha = 1'b1;
   logic [OW-1:0] out_sample;
   logic          out_valid;
   logic          path_sel;
   logic          xfade_busy;

   alpha_path_exchanger #(
      .GAIN_SHIFT(GS), .XFADE_LOG2(XL), .HOLD_SAMPLES(HOLD)
   ) dut (
      .CLK_3M(CLK_3M), .reset(reset), .sample_valid(sample_valid),
      .hdr_value(hdr_value), .ldr_value(ldr_value), .alpha(alpha),
      .out_sample(out_sample), .out_valid(out_valid),
      .path_sel(path_sel), .xfade_busy(xfade_busy)
   );

   always #5 CLK_3M = ~CLK_3M;

   typedef struct {
      int out;
      bit psel;
      bit busy;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   int   txn = 0;

   // Reference model: weight k walks toward the alpha target, one step per sample
   int   m_k = 0;
   int   m_cnt = 0;
   bit   m_moving = 0;
   bit   m_psel = 0;

   task automatic model_reset();
      m_k = 0; m_cnt = 0; m_moving = 0; m_psel = 0;
   endtask

   task automatic model_step(input int h, input int l, input bit a, output exp_t e);
      int     tk;
      longint num, q;
      tk = a ? 0 : N;
      if (m_moving) begin
         if (m_k < tk) m_k++;
         else if (m_k > tk) m_k--;
         if (m_k == tk) m_moving = 0;
      end else if (m_k != tk) begin
         m_cnt++;
         if (m_cnt == HOLD) begin
            m_moving = 1;
            m_cnt = 0;
         end
      end else begin
         m_cnt = 0;
      end
      if (!m_moving) m_psel = (m_k == N);
      num = longint'(h) * (1 << GS) * (N - m_k) + longint'(l) * m_k;
      q = num / N;
      if (num < 0 && (num % N) != 0) q = q - 1;
      e.out  = int'(q);
      e.psel = m_psel;
      e.busy = m_moving;
   endtask

   task automatic send(input int h, input int l, input bit a);
      exp_t e;
      @(posedge CLK_3M);
      #2;
      sample_valid = 1'b1;
      hdr_value = h[8:0];
      ldr_value = l[8:0];
      alpha = a;
      model_step(h, l, a, e);
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK_3M);
         #2;
         sample_valid = 1'b0;
         hdr_value = 9'($urandom_range(0, 511));
         ldr_value = 9'($urandom_range(0, 511));
         alpha = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic do_reset();
      @(posedge CLK_3M);
      #2;
      sample_valid = 1'b0;
      reset = 1'b0;
      model_reset();
      @(posedge CLK_3M);
      #1;
      vectors++;
      if (out_sample !== '0 || out_valid !== 1'b0 || path_sel !== 1'b0 || xfade_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got out=%0d valid=%b psel=%b busy=%b, want all 0",
                  $signed(out_sample), out_valid, path_sel, xfade_busy);
      end
      #1;
      reset = 1'b1;
   endtask

   // Remember whether a sample was accepted on each edge, for the latency check
   logic vld_at_edge = 1'b0;
   always @(posedge CLK_3M) vld_at_edge <= sample_valid & reset;

   // Monitor: pops the scoreboard whenever an output is presented or due
   always @(negedge CLK_3M) begin
      if (out_valid || vld_at_edge) begin
         vectors++;
         if (out_valid !== vld_at_edge) begin
            miscompares++;
            $display("FAIL out_valid_timing: got %b want %b at %0t", out_valid, vld_at_edge, $time);
         end
         if (vld_at_edge) begin
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL scoreboard_empty: got output %0d, want no output", $signed(out_sample));
            end else begin
               mon_e = sb.pop_front();
               txn++;
               $display("txn %0d: out=%0d psel=%b busy=%b (exp %0d %b %b)", txn,
                        $signed(out_sample), path_sel, xfade_busy, mon_e.out, mon_e.psel, mon_e.busy);
               if (int'($signed(out_sample)) != mon_e.out) begin
                  miscompares++;
                  $display("FAIL out_sample: got %0d want %0d", $signed(out_sample), mon_e.out);
               end
               if (path_sel !== mon_e.psel) begin
                  miscompares++;
                  $display("FAIL path_sel: got %b want %b", path_sel, mon_e.psel);
               end
               if (xfade_busy !== mon_e.busy) begin
                  miscompares++;
                  $display("FAIL xfade_busy: got %b want %b", xfade_busy, mon_e.busy);
               end
            end
         end
      end
   end

   initial begin
      bit ra;
      do_reset();
      // steady HDR
      for (int i = 0; i < 5; i++) send(10, 200, 1'b1);
      // full crossfade to LDR, then back to HDR
      for (int i = 0; i < 12; i++) send(10, 200, 1'b0);
      for (int i = 0; i < 12; i++) send(10, 200, 1'b1);
      // short glitch, no crossfade
      for (int i = 0; i < 3; i++) send(10, 200, 1'b0);
      for (int i = 0; i < 3; i++) send(10, 200, 1'b1);
      // crossfade to k=4 then reverse
      for (int i = 0; i < 8; i++) send(10, 200, 1'b0);
      for (int i = 0; i < 5; i++) send(10, 200, 1'b1);
      // negative values mid-crossfade, k=3
      for (int i = 0; i < 7; i++) send(-32, -1, 1'b0);
      // on to k=5, gap, reset, then pure HDR
      for (int i = 0; i < 2; i++) send(-32, -1, 1'b0);
      idle(2);
      do_reset();
      send(-32, -1, 1'b0);
      idle(1);
      // randomized: alpha runs, value extremes, gaps, occasional resets
      ra = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) ra = ~ra;
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 40) == 0) do_reset();
            else idle(int'($urandom_range(1, 2)));
         end
         send(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256, ra);
      end
      idle(3);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
